// File: rtl/pipe1_reader.sv
// Burst readback from a 1-cycle-latency result memory into a small output FIFO.
// Tracks a running checksum of words accepted by the consumer.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | waiting for start; checksum holds last burst
//   S_READ  | issuing memory reads as buffer space allows
//   S_DRAIN | all reads issued, remaining words still to transfer
//   S_FIN   | one-cycle done pulse
module pipe1_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LVL_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_left;
    logic [ADDR_W:0]   xf_left;
    logic              rd_pending;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic [DATA_W-1:0] csum;

    logic              push, pop, room, issue, accept;
    logic [LVL_W-1:0]  level;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push  = rd_pending;
    assign pop   = (occ != '0) && out_ready;
    // Reads in flight count against buffer space; a pop this cycle frees one slot.
    assign level = LVL_W'(occ) + LVL_W'(rd_pending);
    assign room  = level < (LVL_W'(FIFO_DEPTH) + LVL_W'(pop));
    assign issue = (state == S_READ) && (rd_left != '0) && room;
    assign accept = (state == S_IDLE) && start;

    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (count == '0) ? S_FIN : S_READ;
            end
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = issue;
                if (issue && rd_left == (ADDR_W+1)'(1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pop && xf_left == (ADDR_W+1)'(1)) state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            rd_left    <= '0;
            xf_left    <= '0;
            rd_pending <= 1'b0;
            pend_addr  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            csum       <= '0;
        end else begin
            state      <= state_nx;
            rd_pending <= issue;
            pend_addr  <= rd_addr;
            if (accept) begin
                rd_addr <= base_addr;
                rd_left <= count;
                xf_left <= count;
                csum    <= '0;
            end else begin
                if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_left <= rd_left - 1'b1;
                end
                if (pop) begin
                    xf_left <= xf_left - 1'b1;
                    csum    <= csum + out_data;
                end
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: out_valid gates everything read from it.
    always_ff @(posedge clk1) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rd_data;
            fifo_addr[wr_ptr] <= pend_addr;
        end
    end

    assign mem_rd_addr = rd_addr;
    assign out_valid   = (occ != '0);
    assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_addr    = out_valid ? fifo_addr[rd_ptr] : '0;
    assign checksum    = csum;

endmodule

// File: tb/tb_pipe1_reader.sv
// Self-checking bench for pipe1_reader: memory model mem[k]=k+100, a scoreboard
// queue of expected {addr,data} words, and per-scenario tasks.
`timescale 1ns/1ps
module tb_pipe1_reader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 3;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_issued = 0;
    int xfers = 0;
    int last_xfer_cyc = 0;
    logic [DATA_W-1:0] exp_sum;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    pipe1_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
        .checksum(checksum)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        cyc <= cyc + 1;
        mem_rd_data <= mem_rd_en ? (DATA_W'(mem_rd_addr) + 16'd100) : 16'hDEAD;
    end

    // Scoreboard and buffer-level monitor.
    always @(negedge clk1) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                int lvl;
                lvl = rd_issued - xfers - ((out_valid && out_ready) ? 1 : 0);
                n_cmp++;
                if (lvl >= DEPTH) begin
                    n_fail++;
                    $display("FAIL occupancy: read issued with level %0d, limit %0d", lvl, DEPTH);
                end
                rd_issued++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got addr %0d data %0d, expected none", out_addr, out_data);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if ({out_addr, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL word: got addr %0d data %0d, expected addr %0d data %0d",
                                 out_addr, out_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
                xfers++;
                last_xfer_cyc = cyc;
            end
        end
    end

    // Called and returns at #1 after a posedge; leaves the bench in cycle 1 of the burst.
    task automatic start_burst(input logic [ADDR_W-1:0] b, input int cnt);
        logic [ADDR_W-1:0] a;
        exp_sum = '0;
        for (int k = 0; k < cnt; k++) begin
            a = b + ADDR_W'(k);
            exp_q.push_back({a, DATA_W'(a) + 16'd100});
            exp_sum = exp_sum + DATA_W'(a) + 16'd100;
        end
        rd_issued = 0;
        xfers = 0;
        base_addr = b;
        count = (ADDR_W+1)'(cnt);
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                @(posedge clk1); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        n_cmp++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, busy, done, checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%0b addr=%0d v=%0b d=%0d a=%0d busy=%0b done=%0b cs=%0d, expected all 0",
                     mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, busy, done, checksum);
        end
        rst_n = 1'b1;
        @(posedge clk1); #1;
    endtask

    task automatic test_basic;
        bit got;
        start_burst(8'd125, 6);
        n_cmp++;
        if ({mem_rd_en, busy, out_valid, mem_rd_addr} !== {1'b1, 1'b1, 1'b0, 8'd125}) begin
            n_fail++;
            $display("FAIL basic_cycle1: en=%0b busy=%0b v=%0b addr=%0d, expected 1 1 0 125",
                     mem_rd_en, busy, out_valid, mem_rd_addr);
        end
        @(posedge clk1); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle2_valid: got %0b expected 0", out_valid);
        end
        @(posedge clk1); #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_stream cycle %0d: valid=%0b done=%0b expected 1 0", 3 + i, out_valid, done);
            end
            @(posedge clk1); #1;
        end
        wait_done(4, got);
        n_cmp++;
        if (!got || cyc != last_xfer_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: got=%0b at cycle %0d, expected at %0d", got, cyc, last_xfer_cyc + 1);
        end
        n_cmp++;
        if (checksum !== exp_sum || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_checksum: cs=%0d busy=%0b left=%0d expected cs=%0d busy=0 left=0",
                     checksum, busy, exp_q.size(), exp_sum);
        end
        repeat (3) @(posedge clk1);
        #1;
        n_cmp++;
        if (checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL idle_hold_checksum: got %0d expected %0d", checksum, exp_sum);
        end
    endtask

    task automatic test_wrap;
        bit got;
        start_burst(8'd254, 4);
        wait_done(40, got);
        n_cmp++;
        if (!got || exp_q.size() != 0 || rd_issued != 4 || checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL wrap: done=%0b left=%0d reads=%0d cs=%0d expected 1 0 4 %0d",
                     got, exp_q.size(), rd_issued, checksum, exp_sum);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_backpressure;
        bit got;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        got = 1'b0;
        start_burst(8'd40, 10);
        for (int i = 0; i < 200 && !got; i++) begin
            out_ready = pat[i % 4];
            @(posedge clk1); #1;
            if (done) got = 1'b1;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (!got || exp_q.size() != 0 || rd_issued != 10 || xfers != 10) begin
            n_fail++;
            $display("FAIL backpressure: done=%0b left=%0d reads=%0d xfers=%0d expected 1 0 10 10",
                     got, exp_q.size(), rd_issued, xfers);
        end
        n_cmp++;
        if (checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL backpressure_checksum: got %0d expected %0d", checksum, exp_sum);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_zero;
        start_burst(8'd7, 0);
        n_cmp++;
        if ({done, busy, mem_rd_en, checksum} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL zero_count: done=%0b busy=%0b en=%0b cs=%0d expected 1 0 0 0",
                     done, busy, mem_rd_en, checksum);
        end
        @(posedge clk1); #1;
        n_cmp++;
        if (done !== 1'b0 || rd_issued != 0) begin
            n_fail++;
            $display("FAIL zero_after: done=%0b reads=%0d expected 0 0", done, rd_issued);
        end
    endtask

    task automatic test_ignore_start;
        bit got;
        start_burst(8'd10, 5);
        base_addr = 8'd50;
        count = 9'd8;
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        wait_done(40, got);
        n_cmp++;
        if (!got || exp_q.size() != 0 || rd_issued != 5 || checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL ignore_start: done=%0b left=%0d reads=%0d cs=%0d expected 1 0 5 %0d",
                     got, exp_q.size(), rd_issued, checksum, exp_sum);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_reset_mid;
        bit got;
        bit seen;
        start_burst(8'd20, 20);
        repeat (4) @(posedge clk1);
        #1;
        rst_n = 1'b0;
        @(posedge clk1); #1;
        n_cmp++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, busy, done, checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: en=%0b addr=%0d v=%0b d=%0d a=%0d busy=%0b done=%0b cs=%0d, expected all 0",
                     mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, busy, done, checksum);
        end
        exp_q.delete();
        rd_issued = 0;
        xfers = 0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk1); #1;
            if (done || out_valid || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: activity after abort got 1 expected 0");
        end
        start_burst(8'd3, 3);
        wait_done(40, got);
        n_cmp++;
        if (!got || exp_q.size() != 0 || rd_issued != 3 || checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: done=%0b left=%0d reads=%0d cs=%0d expected 1 0 3 %0d",
                     got, exp_q.size(), rd_issued, checksum, exp_sum);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_full;
        bit got;
        start_burst(8'd0, 256);
        wait_done(400, got);
        n_cmp++;
        if (!got || exp_q.size() != 0 || rd_issued != 256 || xfers != 256) begin
            n_fail++;
            $display("FAIL full_burst: done=%0b left=%0d reads=%0d xfers=%0d expected 1 0 256 256",
                     got, exp_q.size(), rd_issued, xfers);
        end
        n_cmp++;
        if (checksum !== 16'd58240) begin
            n_fail++;
            $display("FAIL full_checksum: got %0d expected 58240", checksum);
        end
        @(posedge clk1); #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_wrap;
        test_backpressure;
        test_ignore_start;
        test_reset_mid;
        test_full;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
